// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: drives a req/ack instruction memory and feeds IF/ID
// through a one-entry output slot backed by a one-entry skid register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o,
  output logic        flush_o
);

  localparam logic [1:0] S_WAIT    = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        vld;
  } slot_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } skid_t;

  logic [1:0]  state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] tgt_q, tgt_d;
  slot_t       slot_q, slot_d;
  skid_t       skid_q, skid_d;

  logic [31:0] redir_tgt;
  logic [31:0] fetch_pc4;
  logic        slot_free;
  logic        consume;
  logic [1:0]  unused_addr_lo;

  assign redir_tgt      = {redirect_addr_i[31:2], 2'b00};
  assign unused_addr_lo = redirect_addr_i[1:0];
  assign fetch_pc4      = req_addr_q + 32'd4;
  assign slot_free      = ~slot_q.vld | ~stall_i;
  assign consume        = slot_q.vld & ~stall_i & ~redirect_i;

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    tgt_d      = tgt_q;
    slot_d     = slot_q;
    skid_d     = skid_q;

    if (redirect_i) begin
      // Everything buffered or in flight is wrong-path; redirect beats stall/ack.
      slot_d = '0;
      skid_d = '0;
      case (state_q)
        S_WAIT: begin
          if (imem_ack_i) begin
            req_addr_d = redir_tgt;
          end else begin
            tgt_d   = redir_tgt;
            state_d = S_DISCARD;
          end
        end
        S_DISCARD: tgt_d = redir_tgt;
        default: begin
          req_addr_d = redir_tgt;
          state_d    = S_WAIT;
        end
      endcase
    end else begin
      case (state_q)
        S_WAIT: begin
          if (imem_ack_i) begin
            req_addr_d = fetch_pc4;
            if (slot_free) begin
              slot_d.instr = imem_data_i;
              slot_d.pc4   = fetch_pc4;
              slot_d.vld   = 1'b1;
            end else begin
              skid_d.instr = imem_data_i;
              skid_d.pc4   = fetch_pc4;
              state_d      = S_HOLD;
            end
          end else if (consume) begin
            slot_d = '0;
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            slot_d.instr = skid_q.instr;
            slot_d.pc4   = skid_q.pc4;
            slot_d.vld   = 1'b1;
            state_d      = S_WAIT;
          end
        end
        S_DISCARD: begin
          // The outstanding request must complete before the target can be issued.
          if (imem_ack_i) begin
            req_addr_d = tgt_q;
            state_d    = S_WAIT;
          end
        end
        default: state_d = S_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_WAIT;
      req_addr_q <= RESET_PC;
      tgt_q      <= '0;
      slot_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      tgt_q      <= tgt_d;
      slot_q     <= slot_d;
      skid_q     <= skid_d;
    end
  end

  assign imem_req_o  = rst_n & ((state_q == S_WAIT) | (state_q == S_DISCARD));
  assign imem_addr_o = req_addr_q;
  assign instr_o     = slot_q.instr;
  assign pc4_o       = slot_q.pc4;
  assign valid_o     = slot_q.vld;
  assign flush_o     = rst_n & redirect_i;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed per-cycle vector tables plus a randomized run
// checked against an instruction-stream model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] instr_o;
  logic [31:0] pc4_o;
  logic        valid_o;
  logic        flush_o;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_addr_i(redirect_addr_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i), .instr_o(instr_o),
    .pc4_o(pc4_o), .valid_o(valid_o), .flush_o(flush_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h1300_0013;
  endfunction

  // Memory: acks once a request has been held for cur_wait extra cycles.
  int mem_cnt;
  int mem_fixed = 0;
  bit mem_rand = 1'b0;
  int rnd_wait;
  int cur_wait;
  always_comb cur_wait = mem_rand ? rnd_wait : mem_fixed;
  assign imem_ack_i  = imem_req_o && (mem_cnt >= cur_wait);
  assign imem_data_i = imem_ack_i ? memf(imem_addr_o) : 32'hDEAD_BEEF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cnt  <= 0;
      rnd_wait <= 0;
    end else if (imem_req_o) begin
      if (imem_ack_i) begin
        mem_cnt  <= 0;
        rnd_wait <= int'($urandom_range(0, 3));
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [99:0] act, input logic [99:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    bit          stall;
    bit          redir;
    logic [31:0] raddr;
    logic        req;
    logic        ack;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        flush;
  } vec_t;

  function automatic vec_t mk(bit s, bit r, logic [31:0] ra, logic q, logic k,
                              logic [31:0] a, logic v, logic [31:0] i, logic [31:0] p,
                              logic f);
    vec_t t;
    t.stall = s; t.redir = r; t.raddr = ra; t.req = q; t.ack = k; t.addr = a;
    t.valid = v; t.instr = i; t.pc4 = p; t.flush = f;
    return t;
  endfunction

  // Entered at posedge+1; drives, compares at negedge, returns at next posedge+1.
  task automatic apply_row(input string nm, input vec_t v);
    stall_i = v.stall;
    redirect_i = v.redir;
    redirect_addr_i = v.raddr;
    @(negedge clk);
    chk(nm, {imem_req_o, imem_ack_i, (imem_req_o ? imem_addr_o : 32'h0), valid_o, instr_o,
             pc4_o, flush_o},
        {v.req, v.ack, v.addr, v.valid, v.instr, v.pc4, v.flush});
    @(posedge clk);
    #1;
  endtask

  vec_t tz[12];
  vec_t tl[14];

  logic [31:0] exp_pc;
  bit          prev_redir, prev_hold, prev_pend;
  logic [64:0] held;
  logic [31:0] prev_addr;
  int          consumed;

  initial begin
    // Zero-wait memory: streaming, stall into skid, redirects (incl. with stall+ack).
    tz[0]  = mk(0, 0, 0,        1, 1, 32'h0,   0, 0, 0, 0);
    tz[1]  = mk(0, 0, 0,        1, 1, 32'h4,   1, memf(32'h0), 32'h4, 0);
    tz[2]  = mk(1, 0, 0,        1, 1, 32'h8,   1, memf(32'h4), 32'h8, 0);
    tz[3]  = mk(1, 0, 0,        0, 0, 32'h0,   1, memf(32'h4), 32'h8, 0);
    tz[4]  = mk(1, 0, 0,        0, 0, 32'h0,   1, memf(32'h4), 32'h8, 0);
    tz[5]  = mk(0, 0, 0,        0, 0, 32'h0,   1, memf(32'h4), 32'h8, 0);
    tz[6]  = mk(0, 0, 0,        1, 1, 32'hC,   1, memf(32'h8), 32'hC, 0);
    tz[7]  = mk(0, 1, 32'h43,   1, 1, 32'h10,  1, memf(32'hC), 32'h10, 1);
    tz[8]  = mk(0, 0, 0,        1, 1, 32'h40,  0, 0, 0, 0);
    tz[9]  = mk(1, 1, 32'h100,  1, 1, 32'h44,  1, memf(32'h40), 32'h44, 1);
    tz[10] = mk(0, 0, 0,        1, 1, 32'h100, 0, 0, 0, 0);
    tz[11] = mk(0, 0, 0,        1, 1, 32'h104, 1, memf(32'h100), 32'h104, 0);
    // Latency-3 memory: single-cycle valid, then redirect while waiting at 8.
    tl[0]  = mk(0, 0, 0,        1, 0, 32'h0,   0, 0, 0, 0);
    tl[1]  = mk(0, 0, 0,        1, 0, 32'h0,   0, 0, 0, 0);
    tl[2]  = mk(0, 0, 0,        1, 1, 32'h0,   0, 0, 0, 0);
    tl[3]  = mk(0, 0, 0,        1, 0, 32'h4,   1, memf(32'h0), 32'h4, 0);
    tl[4]  = mk(0, 0, 0,        1, 0, 32'h4,   0, 0, 0, 0);
    tl[5]  = mk(0, 0, 0,        1, 1, 32'h4,   0, 0, 0, 0);
    tl[6]  = mk(0, 1, 32'h40,   1, 0, 32'h8,   1, memf(32'h4), 32'h8, 1);
    tl[7]  = mk(0, 0, 0,        1, 0, 32'h8,   0, 0, 0, 0);
    tl[8]  = mk(0, 0, 0,        1, 1, 32'h8,   0, 0, 0, 0);
    tl[9]  = mk(0, 0, 0,        1, 0, 32'h40,  0, 0, 0, 0);
    tl[10] = mk(0, 0, 0,        1, 0, 32'h40,  0, 0, 0, 0);
    tl[11] = mk(0, 0, 0,        1, 1, 32'h40,  0, 0, 0, 0);
    tl[12] = mk(0, 0, 0,        1, 0, 32'h44,  1, memf(32'h40), 32'h44, 0);
    tl[13] = mk(0, 0, 0,        1, 0, 32'h44,  0, 0, 0, 0);

    // Reset state, with redirect_i high to show flush_o is gated.
    redirect_i = 1'b1;
    redirect_addr_i = 32'h80;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 100'({imem_req_o, flush_o, valid_o, instr_o, pc4_o}), 100'(0));
    @(posedge clk);
    #1;
    redirect_i = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) apply_row($sformatf("zw[%0d]", i), tz[i]);

    // Reset mid-WAIT with a valid slot: outputs drop immediately.
    rst_n = 1'b0;
    #1;
    chk("async_reset", 100'({imem_req_o, valid_o, instr_o, pc4_o}), 100'(0));
    mem_fixed = 2;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) apply_row($sformatf("lat3[%0d]", i), tl[i]);

    // Randomized run against the instruction-stream model.
    rst_n = 1'b0;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    mem_rand = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_pc = 32'h0;
    prev_redir = 1'b0; prev_hold = 1'b0; prev_pend = 1'b0;
    held = '0; prev_addr = '0; consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      stall_i = ($urandom_range(0, 3) == 0);
      redirect_i = ($urandom_range(0, 15) == 0);
      redirect_addr_i = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF7 : $urandom;
      @(negedge clk);
      chk("flush", 100'(flush_o), 100'(redirect_i));
      if (!valid_o) chk("nop_when_invalid", 100'({instr_o, pc4_o}), 100'(0));
      if (prev_redir) chk("valid_after_redirect", 100'(valid_o), 100'(0));
      if (prev_hold) chk("stall_hold", 100'({valid_o, instr_o, pc4_o}), 100'(held));
      if (prev_pend) chk("req_stable", 100'({imem_req_o, imem_addr_o}), 100'({1'b1, prev_addr}));
      if (valid_o && !stall_i && !redirect_i) begin
        chk("stream", 100'({instr_o, pc4_o}), 100'({memf(exp_pc), exp_pc + 32'd4}));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (redirect_i) exp_pc = redirect_addr_i & 32'hFFFF_FFFC;
      prev_redir = redirect_i;
      prev_hold = valid_o && stall_i && !redirect_i;
      held = {valid_o, instr_o, pc4_o};
      prev_pend = imem_req_o && !imem_ack_i;
      prev_addr = imem_addr_o;
      @(posedge clk);
      #1;
    end
    chk("liveness", 100'(consumed > 100), 100'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch sequencer that feeds the IF/ID pipeline register. It owns the fetch address and runs a req/ack handshake with a variable-latency instruction memory. Returned words are buffered through a one-entry output slot plus a one-entry skid register. On a branch or jump redirect from ID it flushes wrong-path work, and it presents instruction and PC+4 to IF/ID under control of the hazard-detection stall.

## Interface
- RESET_PC, 32'h0000_0000: address of the first fetch after reset; must be word-aligned.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  hazard-detection stall; IF/ID does not capture this cycle.
- redirect_i  in  1  taken branch/jump from ID; all in-flight and buffered fetches are wrong-path.
- redirect_addr_i  in  32  redirect target; bits [1:0] ignored and forced to 0.
- imem_req_o  out  1  memory request.
- imem_addr_o  out  32  request address; stable while imem_req_o is high.
- imem_ack_i  in  1  one-cycle response strobe; may arrive in the same cycle as the request or any later cycle.
- imem_data_i  in  32  instruction word, valid only with imem_ack_i.
- instr_o  out  32  instruction to IF/ID; 0 (NOP) whenever valid_o=0.
- pc4_o  out  32  fetch address + 4 of instr_o; 0 whenever valid_o=0.
- valid_o  out  1  output slot holds a correct-path instruction.
- flush_o  out  1  flush to IF/ID; combinational copy of redirect_i.

## Operation
- Registers:
  - req_addr_q: address of the current or next request.
  - tgt_q: pending redirect target.
  - Output slot: instr_o, pc4_o, valid_o.
  - Skid: skid_instr_q, skid_pc4_q.
  - State.
- Derived terms:
  - slot_free = ~valid_o | ~stall_i.
  - Consumption occurs on an edge with valid_o=1, stall_i=0 and redirect_i=0.
- States:
  - WAIT: imem_req_o=1, imem_addr_o=req_addr_q.
  - HOLD: imem_req_o=0.
  - DISCARD: imem_req_o=1, imem_addr_o=req_addr_q, with the old address retained until ack.
- WAIT, ack, no redirect:
  - If slot_free: slot <= {imem_data_i, req_addr_q+4, 1}. Stay WAIT.
  - Otherwise: skid <= {imem_data_i, req_addr_q+4}. Go to HOLD.
  - In both cases req_addr_q += 4.
- WAIT, no ack: if the slot is consumed, valid_o <= 0 and instr_o and pc4_o <= 0. Otherwise the slot holds.
- HOLD: when stall_i=0 and redirect_i=0, slot <= skid with valid_o=1, then go to WAIT.
- DISCARD, ack: drop imem_data_i. req_addr_q <= tgt_q. Go to WAIT.
- Redirect has priority over stall, ack and consumption. On a redirect edge:
  - Slot and skid are cleared (valid_o=0, instr_o=0, pc4_o=0).
  - If in WAIT with ack that cycle, or in HOLD: req_addr_q <= target, go to WAIT.
  - If in WAIT without ack: tgt_q <= target, go to DISCARD.
  - If in DISCARD: tgt_q <= the new target and stay in DISCARD; the latest redirect wins.
- Arithmetic: address +4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset, asynchronous, immediate:
  - State=WAIT, req_addr_q=RESET_PC, tgt_q=0.
  - Slot and skid = 0, valid_o=0.
  - While rst_n is low: imem_req_o=0 and flush_o=0.
- The first request is visible in the first cycle with rst_n high.
- Reset mid-transaction abandons the outstanding request. The memory must also be reset; a stale ack is not tolerated.
- Latency:
  - Ack at edge t gives valid_o=1 from cycle t+1.
  - With a zero-wait memory (ack in the same cycle as the request), throughput is one instruction per cycle with no bubbles.
- flush_o has zero cycles of latency from redirect_i. The first correct-path request (target address) is issued in the cycle after the redirect edge, or in the cycle after the discarded ack.
- imem_req_o never drops between assertion and ack, except on reset.
- Stall:
  - Slot contents are held unchanged for the entire stall.
  - At most two fetched words are outstanding (slot plus skid); no further request is issued while in HOLD.

## Test plan
- Reset release, zero-wait memory returning data = address: imem_addr_o = 0, 4, 8 on consecutive cycles. valid_o rises 1 cycle after release; pc4_o = 4, 8, 12 with matching instr_o.
- Memory latency 3: imem_addr_o=0 is held for 3 cycles and ack arrives on the 3rd. valid_o goes high for exactly one cycle with instr_o = the word, then drops to 0 with instr_o=0.
- stall_i high for 3 cycles while slot is full and ack arrives: go to HOLD with imem_req_o=0 and instr_o unchanged. After stall falls, the skid word appears next cycle, fetch resumes at the next address, and no instruction is lost or duplicated.
- redirect_i to 32'h40 while in WAIT without ack at address 8: flush_o=1 in the same cycle and valid_o=0 next cycle. The late ack data for address 8 is dropped, then imem_addr_o=32'h40 and pc4_o=32'h44.
- redirect_i, stall_i and ack all in the same cycle: redirect wins, slot and skid are empty, and the next request goes to the target.
- rst_n pulsed low mid-WAIT: valid_o, instr_o and imem_req_o go to 0 immediately. After release, the fetch restarts at RESET_PC.
